// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter feeding one MSB-first serial shifter.
// An accepted word is loaded into a shift register and sent one bit per
// cycle. Back-to-back words with no idle bit are possible when IDLE_GAP is 0.
// Otherwise IDLE_GAP forced-zero cycles follow each word, and then at least
// one IDLE cycle.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high
//   enable      permits new grants; the word in flight always completes
//   reqValid    per-requester word-valid
//   reqData     packed words, word i at bits [i*WORD_SIZE +: WORD_SIZE]
//   reqReady    one-hot accept strobe (combinational)
//   serialOut   serial data, MSB first
//   frameStart  high while serialOut carries a word's MSB
//   busy        high while serialOut carries word data
//   grantId     requester currently (or most recently) being shifted
module serial_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WORD_SIZE = 23,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   reqData,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic                           serialOut,
    output logic                           frameStart,
    output logic                           busy,
    output logic [2:0]                     grantId
);

    localparam int unsigned CNT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0]   CNT_TOP  = CNT_W'(WORD_SIZE - 1);
    localparam logic [GAP_W-1:0]   GAP_TOP  = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam bit                 LSB_ARB  = (IDLE_GAP == 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [GAP_W-1:0]       gap_q,   gap_d;
    logic [IDX_W-1:0]       rr_q,    rr_d;
    logic [ID_W-1:0]        grant_q, grant_d;

    logic [WORD_SIZE-1:0]   words [NUM_REQ];
    logic                   found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       idx;
    logic                   arb_window;
    logic                   accept;
    logic [NUM_REQ-1:0]     ready_raw;

    // Unpack the flat data bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = reqData[g*WORD_SIZE +: WORD_SIZE];
    end

    // Round-robin search: first valid requester starting at rr_q.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((32'(rr_q) + k) % NUM_REQ);
            if (!found && reqValid[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        arb_window = 1'b0;
        accept     = 1'b0;
        ready_raw  = '0;
        serialOut  = 1'b0;
        frameStart = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                arb_window = 1'b1;
            end
            SHIFT: begin
                serialOut  = shift_q[WORD_SIZE-1];
                busy       = 1'b1;
                frameStart = (cnt_q == CNT_TOP);
                shift_d    = shift_q << 1;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // LSB cycle: a back-to-back grant is only possible with no gap.
                    arb_window = LSB_ARB;
                    cnt_d      = CNT_TOP;
                    if (IDLE_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_TOP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept = arb_window && enable && found;
        if (accept) begin
            ready_raw = ONE_HOT0 << win_idx;
            shift_d   = words[win_idx];
            cnt_d     = CNT_TOP;
            state_d   = SHIFT;
            rr_d      = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
            grant_d   = ID_W'(win_idx);
        end
    end

    // Hold off handshakes for as long as reset is asserted.
    assign reqReady = ready_raw & {NUM_REQ{~reset}};
    assign grantId  = grant_q;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= CNT_TOP;
            gap_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: one instance with no idle gap and one
// with IDLE_GAP=3, sharing clock, reset, enable and data.
module tb_serial_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned WS = 23;

    logic              clock;
    logic              reset;
    logic              enable;
    logic [NR-1:0]     reqValid;
    logic [NR*WS-1:0]  reqData;
    logic [NR-1:0]     reqReady;
    logic              serialOut;
    logic              frameStart;
    logic              busy;
    logic [2:0]        grantId;

    logic [NR-1:0]     gValid;
    logic [NR-1:0]     gReady;
    logic              gSerial;
    logic              gFrame;
    logic              gBusy;
    logic [2:0]        gGrant;

    logic [WS-1:0]     words [NR];
    logic [NR-1:0]     exp_r;
    int                checks;
    int                errors;

    serial_tx_arbiter #(.NUM_REQ(NR), .WORD_SIZE(WS), .IDLE_GAP(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .reqValid   (reqValid),
        .reqData    (reqData),
        .reqReady   (reqReady),
        .serialOut  (serialOut),
        .frameStart (frameStart),
        .busy       (busy),
        .grantId    (grantId)
    );

    serial_tx_arbiter #(.NUM_REQ(NR), .WORD_SIZE(WS), .IDLE_GAP(3)) dut_gap (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .reqValid   (gValid),
        .reqData    (reqData),
        .reqReady   (gReady),
        .serialOut  (gSerial),
        .frameStart (gFrame),
        .busy       (gBusy),
        .grantId    (gGrant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        words[0] = 23'h400001;
        words[1] = 23'h2AAAAA;
        words[2] = 23'h155555;
        words[3] = 23'h7FFFFF;
        for (int i = 0; i < NR; i++) reqData[i*WS +: WS] = words[i];

        // Reset state, with requests pending that must not be granted.
        reset    = 1'b1;
        enable   = 1'b1;
        reqValid = 4'b1111;
        gValid   = 4'b0000;
        #1;
        check("rst_ready",  32'(reqReady),   32'h0);
        check("rst_serial", 32'(serialOut),  32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        check("rst_frame",  32'(frameStart), 32'h0);
        check("rst_grant",  32'(grantId),    32'h0);
        tick();
        check("rst_ready_edge", 32'(reqReady), 32'h0);
        check("rst_busy_edge",  32'(busy),     32'h0);
        reqValid = 4'b0000;
        reset    = 1'b0;

        // Single word 23'h400001 from requester 0.
        reqValid = 4'b0001;
        #1;
        check("single_ready", 32'(reqReady), 32'h1);
        tick();
        reqValid = 4'b0000;
        #1;
        check("single_msb_frame", 32'(frameStart), 32'h1);
        check("single_msb_bit",   32'(serialOut),  32'h1);
        check("single_msb_busy",  32'(busy),       32'h1);
        check("single_grant",     32'(grantId),    32'h0);
        check("single_ready_off", 32'(reqReady),   32'h0);
        for (int k = 1; k <= 21; k++) begin
            tick();
            check("single_mid_bit",   32'(serialOut),  32'h0);
            check("single_mid_busy",  32'(busy),       32'h1);
            check("single_mid_frame", 32'(frameStart), 32'h0);
        end
        tick();
        check("single_lsb_bit",  32'(serialOut), 32'h1);
        check("single_lsb_busy", 32'(busy),      32'h1);
        tick();
        check("single_end_bit",  32'(serialOut), 32'h0);
        check("single_end_busy", 32'(busy),      32'h0);

        // All requesters valid from a fresh pointer: grants 0,1,2,3,0 back to back.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        reqValid = 4'b1111;
        #1;
        check("all_first_ready", 32'(reqReady), 32'h1);
        tick();
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 23; k++) begin
                check("all_bit",   32'(serialOut),  32'(words[n % 4][WS-1-k]));
                check("all_busy",  32'(busy),       32'h1);
                check("all_frame", 32'(frameStart), (k == 0) ? 32'h1 : 32'h0);
                check("all_grant", 32'(grantId),    32'(n % 4));
                if (k == 5) check("all_mid_ready", 32'(reqReady), 32'h0);
                if (k == 22) begin
                    if (n == 4) begin
                        reqValid = 4'b0000;
                        #1;
                        check("all_last_ready", 32'(reqReady), 32'h0);
                    end else begin
                        exp_r = 4'b0001 << ((n + 1) % 4);
                        check("all_lsb_ready", 32'(reqReady), 32'(exp_r));
                    end
                end
                tick();
            end
        end
        check("all_end_busy",   32'(busy),       32'h0);
        check("all_end_serial", 32'(serialOut),  32'h0);
        check("all_end_frame",  32'(frameStart), 32'h0);

        // Pointer skip: only requester 2 valid, then the pointer sits at 3.
        reqValid = 4'b0100;
        #1;
        check("skip_ready", 32'(reqReady), 32'h4);
        tick();
        reqValid = 4'b0000;
        check("skip_grant", 32'(grantId),    32'h2);
        check("skip_frame", 32'(frameStart), 32'h1);
        check("skip_msb",   32'(serialOut),  32'(words[2][WS-1]));
        for (int k = 1; k <= 22; k++) tick();
        tick();
        check("skip_end_busy", 32'(busy), 32'h0);
        reqValid = 4'b1111;
        #1;
        check("rr_after_skip", 32'(reqReady), 32'h8);
        tick();
        reqValid = 4'b0000;
        check("rr3_grant", 32'(grantId), 32'h3);

        // Reset in the middle of requester 3's all-ones word.
        for (int k = 1; k <= 10; k++) tick();
        check("pre_reset_bit",  32'(serialOut), 32'h1);
        check("pre_reset_busy", 32'(busy),      32'h1);
        reset = 1'b1;
        #1;
        check("midrst_serial", 32'(serialOut),  32'h0);
        check("midrst_busy",   32'(busy),       32'h0);
        check("midrst_frame",  32'(frameStart), 32'h0);
        check("midrst_grant",  32'(grantId),    32'h0);
        reqValid = 4'b1111;
        #1;
        check("midrst_ready", 32'(reqReady), 32'h0);
        tick();
        check("midrst_busy_edge", 32'(busy), 32'h0);
        reset = 1'b0;
        #1;
        check("postrst_ready", 32'(reqReady), 32'h1);
        tick();
        reqValid = 4'b0000;
        check("postrst_grant", 32'(grantId),    32'h0);
        check("postrst_frame", 32'(frameStart), 32'h1);
        check("postrst_msb",   32'(serialOut),  32'(words[0][WS-1]));
        for (int k = 1; k <= 22; k++) tick();
        tick();
        check("no_resume_busy", 32'(busy), 32'h0);

        // Enable low blocks grants; dropping it mid-word does not truncate.
        enable   = 1'b0;
        reqValid = 4'b0001;
        #1;
        check("en_low_ready", 32'(reqReady), 32'h0);
        tick();
        check("en_low_busy",  32'(busy),     32'h0);
        check("en_low_ready2", 32'(reqReady), 32'h0);
        enable = 1'b1;
        #1;
        check("en_high_ready", 32'(reqReady), 32'h1);
        tick();
        for (int k = 0; k < 23; k++) begin
            if (k == 5) enable = 1'b0;
            check("en_bit",  32'(serialOut), 32'(words[0][WS-1-k]));
            check("en_busy", 32'(busy),      32'h1);
            if (k == 22) check("en_lsb_ready", 32'(reqReady), 32'h0);
            tick();
        end
        check("en_no_regrant_busy",  32'(busy),     32'h0);
        check("en_no_regrant_ready", 32'(reqReady), 32'h0);
        tick();
        check("en_still_idle", 32'(busy), 32'h0);
        reqValid = 4'b0000;
        enable   = 1'b1;

        // IDLE_GAP=3 instance: four zero cycles between LSB and next MSB.
        gValid = 4'b0011;
        #1;
        check("gap_first_ready", 32'(gReady), 32'h1);
        tick();
        gValid = 4'b0010;
        for (int k = 0; k < 23; k++) begin
            check("gap_w0_bit",   32'(gSerial), 32'(words[0][WS-1-k]));
            check("gap_w0_frame", 32'(gFrame),  (k == 0) ? 32'h1 : 32'h0);
            if (k == 22) check("gap_lsb_ready", 32'(gReady), 32'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check("gap_busy",   32'(gBusy),   32'h0);
            check("gap_serial", 32'(gSerial), 32'h0);
            check("gap_ready",  32'(gReady),  32'h0);
            tick();
        end
        check("gap_idle_busy",  32'(gBusy),   32'h0);
        check("gap_idle_ready", 32'(gReady),  32'h2);
        tick();
        gValid = 4'b0000;
        check("gap_w1_frame", 32'(gFrame),  32'h1);
        check("gap_w1_grant", 32'(gGrant),  32'h1);
        check("gap_w1_msb",   32'(gSerial), 32'(words[1][WS-1]));
        check("gap_w1_busy",  32'(gBusy),   32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters (range 2..8).
REQ-002 Parameter WORD_SIZE, default 23, sets the bits per serial word.
REQ-003 Parameter IDLE_GAP, default 0, sets the forced-zero cycles after each word's LSB (range 0..255).
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port enable  input  1  high permits new grants; low blocks new grants only.
REQ-007 Port reqValid  input  NUM_REQ  bit i high = requester i holds a word.
REQ-008 Port reqData  input  NUM_REQ*WORD_SIZE  word i occupies bits i*WORD_SIZE upward.
REQ-009 Port reqReady  output  NUM_REQ  one-hot; bit i high = word i accepted on this edge.
REQ-010 Port serialOut  output  1  serial bit stream, MSB first.
REQ-011 Port frameStart  output  1  high exactly in the cycle serialOut carries a word's MSB.
REQ-012 Port busy  output  1  high in any cycle serialOut carries word data.
REQ-013 Port grantId  output  3  index of the requester whose word is being shifted; holds its last value when idle.

Function
REQ-014 States SHALL be IDLE, SHIFT and GAP.
REQ-015 Handshake: a word transfers on a rising edge where reqValid[i] and reqReady[i] are both high; reqReady SHALL be combinational from state, enable, reqValid and the pointer.
REQ-016 Arbitration: round-robin from pointer rr; the winner is the first i with reqValid[i] high, searching rr, rr+1, ... modulo NUM_REQ.
REQ-017 On each accept, rr SHALL become winner+1 modulo NUM_REQ, and grantId SHALL become the winner.
REQ-018 Arbitration SHALL occur only in IDLE, or in the SHIFT LSB cycle when IDLE_GAP is 0, and only when enable is high.
REQ-019 In all other cycles, reqReady SHALL be all zero.
REQ-020 Accept SHALL load the word into the shift register and set the bit counter to WORD_SIZE-1; the next state is SHIFT.
REQ-021 Latency: the MSB SHALL appear on serialOut in the cycle after the accept edge.
REQ-022 In SHIFT: serialOut = shift register MSB; shift left by one each cycle; counter decrements; busy high.
REQ-023 frameStart SHALL be high when the counter equals WORD_SIZE-1.
REQ-024 LSB cycle (counter 0) with an accept: reload, giving back-to-back words with no idle bit.
REQ-025 LSB cycle without an accept: go to GAP if IDLE_GAP>0, else IDLE.
REQ-026 GAP SHALL last exactly IDLE_GAP cycles, then enter IDLE; IDLE lasts at least one cycle.
REQ-027 In IDLE and GAP: serialOut, busy and frameStart SHALL be 0.
REQ-028 enable low during SHIFT SHALL not truncate the current word; the word completes normally.
REQ-029 reqValid dropping without a handshake SHALL have no effect; words are never partially sent.
REQ-030 A single requester holding valid continuously SHALL be granted every word slot when the others are idle.

Reset
REQ-031 Reset asserted SHALL immediately force IDLE, serialOut=0, busy=0, frameStart=0, reqReady=0, grantId=0, rr=0, counter=WORD_SIZE-1, shift register 0.
REQ-032 Reset mid-word SHALL discard the word with no resumption.
REQ-033 The first grant after reset release SHALL occur no earlier than the first rising edge with reset low.

Verification (NUM_REQ=4, WORD_SIZE=23, IDLE_GAP=0 unless stated)
REQ-034 Single word: reqValid=0001, data 23'h400001 -> reqReady[0] high for one cycle; next cycle frameStart=1, serialOut=1; then 21 zeros; then 1; then serialOut=0 and busy=0.
REQ-035 All-valid: reqValid=1111 held -> grant order 0,1,2,3,0; frameStart every 23 cycles; busy continuously high.
REQ-036 Pointer skip: grant 0, then only reqValid[2] -> grantId=2; then rr=3.
REQ-037 Mid-word reset: reset asserted during bit index 10 -> serialOut and busy fall before the next edge; after release, reqValid=1111 -> grantId=0.
REQ-038 Enable: enable=0 with reqValid=0001 -> no reqReady; enable dropped at bit 5 -> all 23 bits still sent, and no new grant follows.
REQ-039 Gap: IDLE_GAP=3, two queued words -> exactly 4 zero cycles between the first word's LSB and the second word's MSB.
